// File: rtl/sram_param.sv
// Byte-writable single-port SRAM with a self-clearing INIT sequence.
// Optional per-byte even parity enabled by defining SRAM_PARITY_EN.
module sram_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              addr_err
`ifdef SRAM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nx;
  logic              last;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;

  logic in_range;
  logic req_ok;
  logic do_wr;
  logic do_rd;
  logic bad_addr;

  assign last     = (cnt == ADDR_W'(DEPTH - 1));
  assign busy     = (state == INIT);
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign req_ok   = (state == READY) && (write_en ^ read_en);
  assign do_wr    = req_ok && write_en && in_range;
  assign do_rd    = req_ok && read_en && in_range;
  assign bad_addr = req_ok && !in_range;
  assign rd_word  = in_range ? mem[addr] : '0;

  // State and clear-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // INIT walks the counter once over every word, then parks in READY.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      INIT: begin
        if (last) begin
          state_nx = READY;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      READY: ;
      default: state_nx = INIT;
    endcase
  end

  // Merge enabled bytes of the write word over the stored word.
  always_comb begin
    wr_word = rd_word;
    for (int k = 0; k < NB; k++) begin
      if (byte_en[k]) wr_word[8*k +: 8] = write_data[8*k +: 8];
    end
  end

  // Storage: cleared word by word in INIT, byte-masked writes in READY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) mem[cnt] <= '0;
      else if (do_wr)    mem[addr] <= wr_word;
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] rd_par;
  logic [NB-1:0] wr_par;
  logic [NB-1:0] par_bad;

  assign rd_par = in_range ? par[addr] : '0;

  // Even parity per byte; only enabled bytes get new parity.
  always_comb begin
    wr_par  = rd_par;
    par_bad = '0;
    for (int k = 0; k < NB; k++) begin
      if (byte_en[k]) wr_par[k] = ^write_data[8*k +: 8];
      par_bad[k] = ^{rd_word[8*k +: 8], rd_par[k]};
    end
  end

  // Parity storage tracks the data array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) par[cnt] <= '0;
      else if (do_wr)    par[addr] <= wr_par;
    end
  end

  // Parity flag pulses alongside read_valid.
  always_ff @(posedge clk) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= do_rd && (|par_bad);
  end
`endif

  // Registered read port and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      read_valid <= do_rd;
      addr_err   <= bad_addr;
      if (do_rd) read_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_sram_param.sv
// Self-checking bench for sram_param.
// Main instance DEPTH=16; second instance DEPTH=10 for range errors.
module tb_sram_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        we, re;
  logic [3:0]  ad;
  logic [31:0] wd;
  logic [3:0]  be;
  logic [31:0] rd;
  logic        rv, bsy, ae;

  logic        we10, re10;
  logic [3:0]  ad10;
  logic [31:0] wd10;
  logic [3:0]  be10;
  logic [31:0] rd10;
  logic        rv10, bsy10, ae10;

`ifdef SRAM_PARITY_EN
  logic        pe, pe10;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [16];
  logic [31:0] q [$];

  always #5 clk = ~clk;

  sram_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .write_en(we), .read_en(re),
    .addr(ad), .write_data(wd), .byte_en(be),
    .read_data(rd), .read_valid(rv),
    .busy(bsy), .addr_err(ae)
`ifdef SRAM_PARITY_EN
    , .parity_err(pe)
`endif
  );

  sram_param #(.DATA_W(32), .DEPTH(10), .ADDR_W(4)) u_dut10 (
    .clk(clk), .reset(reset),
    .write_en(we10), .read_en(re10),
    .addr(ad10), .write_data(wd10), .byte_en(be10),
    .read_data(rd10), .read_valid(rv10),
    .busy(bsy10), .addr_err(ae10)
`ifdef SRAM_PARITY_EN
    , .parity_err(pe10)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d,
                    input logic [3:0] b);
    we = 1'b1; re = 1'b0; ad = a; wd = d; be = b;
    tick();
    we = 1'b0;
    for (int k = 0; k < 4; k++)
      if (b[k]) model[a][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic rd_issue(input logic [3:0] a);
    re = 1'b1; we = 1'b0; ad = a;
    q.push_back(model[a]);
    tick();
    re = 1'b0;
  endtask

  task automatic count_busy(output int n, output bit flag);
    n = 0;
    flag = 1'b0;
    while (bsy === 1'b1 && n < 40) begin
      n++;
      if (rv !== 1'b0 || ae !== 1'b0) flag = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    bit flag;
    logic [31:0] e;
    reset = 1'b1;
    tick(); tick(); tick();
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL rst_data got=%h exp=0", rd);
    end
    n_vec++;
    if (rv !== 1'b0 || ae !== 1'b0) begin
      n_err++; $display("FAIL rst_flags rv=%b ae=%b exp=0", rv, ae);
    end
    n_vec++;
    if (bsy !== 1'b1) begin
      n_err++; $display("FAIL rst_busy got=%b exp=1", bsy);
    end
    reset = 1'b0;
    we = 1'b1; ad = 4'd0; wd = 32'hFFFF_FFFF; be = 4'hF;
    count_busy(n, flag);
    we = 1'b0;
    n_vec++;
    if (n != 16) begin
      n_err++; $display("FAIL busy_len got=%0d exp=16", n);
    end
    n_vec++;
    if (flag) begin
      n_err++; $display("FAIL busy_ignore got=1 exp=0");
    end
    rd_issue(4'd5);
    e = q.pop_front();
    n_vec++;
    if (rv !== 1'b1 || rd !== e) begin
      n_err++; $display("FAIL rd5 rv=%b got=%h exp=%h", rv, rd, e);
    end
    rd_issue(4'd0);
    e = q.pop_front();
    n_vec++;
    if (rv !== 1'b1 || rd !== e) begin
      n_err++; $display("FAIL rd0 rv=%b got=%h exp=%h", rv, rd, e);
    end
  endtask

  task automatic test_byte_en();
    logic [31:0] e;
    wr(4'd3, 32'hDEAD_BEEF, 4'hF);
    wr(4'd3, 32'h1122_3344, 4'b0101);
    rd_issue(4'd3);
    e = q.pop_front();
    n_vec++;
    if (rv !== 1'b1 || rd !== 32'hDE22_BE44) begin
      n_err++; $display("FAIL be_mix rv=%b got=%h exp=de22be44", rv, rd);
    end
    wr(4'd3, 32'h0000_0000, 4'h0);
    n_vec++;
    if (ae !== 1'b0) begin
      n_err++; $display("FAIL be_zero_err got=%b exp=0", ae);
    end
    rd_issue(4'd3);
    e = q.pop_front();
    n_vec++;
    if (rd !== e) begin
      n_err++; $display("FAIL be_zero got=%h exp=%h", rd, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    bit bad = 1'b0;
    int nbad = 0;
    wr(4'd3, 32'hCAFE_F00D, 4'hF);
    rd_issue(4'd3);
    e = q.pop_front();
    n_vec++;
    if (rv !== 1'b1 || rd !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL raw rv=%b got=%h exp=cafef00d", rv, rd);
    end
    we = 1'b1; be = 4'hF;
    for (int i = 0; i < 16; i++) begin
      ad = 4'(i);
      wd = $urandom() | 32'h1;
      model[i] = wd;
      tick();
      if (ae !== 1'b0) bad = 1'b1;
    end
    we = 1'b0;
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL full_range_err got=1 exp=0");
    end
    re = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      ad = 4'(i);
      q.push_back(model[i]);
      tick();
      e = q.pop_front();
      if (rv !== 1'b1 || rd !== e) nbad++;
    end
    re = 1'b0;
    n_vec++;
    if (nbad != 0) begin
      n_err++; $display("FAIL b2b_rd got=%0d bad exp=0", nbad);
    end
  endtask

  task automatic test_collision();
    logic [31:0] e;
    wr(4'd2, 32'h0000_0055, 4'hF);
    rd_issue(4'd2);
    e = q.pop_front();
    n_vec++;
    if (rd !== 32'h55) begin
      n_err++; $display("FAIL col_pre got=%h exp=55", rd);
    end
    we = 1'b1; re = 1'b1; ad = 4'd2;
    wd = 32'h0000_00AA; be = 4'hF;
    tick();
    we = 1'b0; re = 1'b0;
    n_vec++;
    if (rv !== 1'b0 || ae !== 1'b0) begin
      n_err++; $display("FAIL col_flags rv=%b ae=%b exp=0", rv, ae);
    end
    n_vec++;
    if (rd !== 32'h55) begin
      n_err++; $display("FAIL col_hold got=%h exp=55", rd);
    end
    rd_issue(4'd2);
    e = q.pop_front();
    n_vec++;
    if (rv !== 1'b1 || rd !== e) begin
      n_err++; $display("FAIL col_mem got=%h exp=%h", rd, e);
    end
  endtask

  task automatic test_addr_err();
    we10 = 1'b1; ad10 = 4'd9; wd10 = 32'h1234_5678; be10 = 4'hF;
    tick();
    we10 = 1'b0;
    n_vec++;
    if (ae10 !== 1'b0) begin
      n_err++; $display("FAIL ae_in got=%b exp=0", ae10);
    end
    re10 = 1'b1; ad10 = 4'd9;
    tick();
    re10 = 1'b0;
    n_vec++;
    if (rv10 !== 1'b1 || rd10 !== 32'h1234_5678) begin
      n_err++; $display("FAIL ae_rd9 rv=%b got=%h exp=12345678", rv10, rd10);
    end
    we10 = 1'b1; ad10 = 4'd12; wd10 = 32'hFFFF_FFFF;
    tick();
    we10 = 1'b0;
    n_vec++;
    if (ae10 !== 1'b1) begin
      n_err++; $display("FAIL ae_wr12 got=%b exp=1", ae10);
    end
    tick();
    n_vec++;
    if (ae10 !== 1'b0) begin
      n_err++; $display("FAIL ae_pulse got=%b exp=0", ae10);
    end
    re10 = 1'b1; ad10 = 4'd12;
    tick();
    re10 = 1'b0;
    n_vec++;
    if (rv10 !== 1'b0 || ae10 !== 1'b1) begin
      n_err++; $display("FAIL ae_rd12 rv=%b ae=%b exp=0/1", rv10, ae10);
    end
    n_vec++;
    if (rd10 !== 32'h1234_5678) begin
      n_err++; $display("FAIL ae_hold got=%h exp=12345678", rd10);
    end
    we10 = 1'b1; ad10 = 4'd10; wd10 = 32'h0;
    tick();
    we10 = 1'b0;
    n_vec++;
    if (ae10 !== 1'b1) begin
      n_err++; $display("FAIL ae_wr10 got=%b exp=1", ae10);
    end
    re10 = 1'b1; ad10 = 4'd9;
    tick();
    re10 = 1'b0;
    n_vec++;
    if (rv10 !== 1'b1 || rd10 !== 32'h1234_5678) begin
      n_err++; $display("FAIL ae_keep got=%h exp=12345678", rd10);
    end
  endtask

  task automatic test_mid_init();
    int n;
    bit flag;
    int nbad = 0;
    logic [31:0] e;
    reset = 1'b1;
    tick();
    n_vec++;
    if (rd !== 32'h0 || bsy !== 1'b1) begin
      n_err++; $display("FAIL rst2 data=%h busy=%b exp=0/1", rd, bsy);
    end
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    count_busy(n, flag);
    n_vec++;
    if (n != 16) begin
      n_err++; $display("FAIL mid_busy got=%0d exp=16", n);
    end
    re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ad = 4'(i);
      q.push_back(model[i]);
      tick();
      e = q.pop_front();
      if (rv !== 1'b1 || rd !== e) nbad++;
    end
    re = 1'b0;
    n_vec++;
    if (nbad != 0) begin
      n_err++; $display("FAIL mid_clear got=%0d bad exp=0", nbad);
    end
  endtask

  initial begin
    we = 0; re = 0; ad = 0; wd = 0; be = 0;
    we10 = 0; re10 = 0; ad10 = 0; wd10 = 0; be10 = 0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    test_reset();
    test_byte_en();
    test_back_to_back();
    test_collision();
    test_addr_err();
    test_mid_init();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
